main_mem_ctrl: RTL and testbench
================================

# main_mem_ctrl

Memory controller between the two L1 caches and main memory. It accepts block-granular requests from the icache port and the dcache port and holds at most one outstanding request per port. A single fixed-latency memory engine serves these requests, with icache having priority. The engine returns exactly one single-cycle response pulse per request to the requesting cache. The block contains the main-memory block array itself, so it is the responder end of each cache's mem_ctrl request/response interface.

## Interface
Parameters:
- N_BLOCKS, 1024: number of `BLOCK_DATA_WIDTH`-bit blocks in the array. Must be a power of two.
- MEM_LATENCY, 4: number of engine BUSY cycles per request. Must be at least 1.

Ports:
- clk  in  1  the only clock; all state changes on posedge.
- rst_aL  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  icache request. Icache requests are always READ.
- ic_req_block_addr  in  main_mem_block_addr_t  icache block address.
- ic_req_ready  out  1  equals rst_aL. The icache is never stalled.
- dc_req_valid  in  1  dcache request.
- dc_req_type  in  req_type_t  READ or WRITE.
- dc_req_block_addr  in  main_mem_block_addr_t  dcache block address.
- dc_req_block_data  in  block_data_t  write data; ignored for READ.
- dc_req_ready  out  1  high when no dcache request is pending.
- ic_resp_valid  out  1  one-cycle response pulse to the icache.
- ic_resp_block_data  out  block_data_t  block read for the icache.
- dc_resp_valid  out  1  one-cycle response pulse to the dcache.
- dc_resp_block_data  out  block_data_t  read data, or the echoed write data for WRITE.

## Operation
- Array index = low $clog2(N_BLOCKS) bits of the block address. Upper bits are ignored, so addresses alias.
- The array is not reset; its contents survive rst_aL.
- Per-port request slot: pending flag, type, address and data registers.
  - An accept (valid & ready at posedge) loads the slot and sets pending.
  - dc_req_ready = ~dc_pending.
  - An ic_req_valid while ic_pending is set is a protocol violation. Add an assertion; the RTL behaviour in that case is undefined.
- Engine FSM, states IDLE, BUSY, RESP, with owner register (IC/DC) and a counter of $clog2(MEM_LATENCY+1) bits:
  - IDLE: if ic_pending, go to BUSY with owner=IC. Else if dc_pending, go to BUSY with owner=DC. Load cnt=MEM_LATENCY-1.
  - BUSY: if cnt==0, go to RESP; else decrement cnt.
  - RESP entry edge: resp_data register ← array[idx] for READ, or the slot data for WRITE.
  - RESP: the owner's resp_valid is 1 for exactly this one cycle.
  - RESP exit edge: a WRITE updates array[idx]; the owner's pending is cleared; go to IDLE.
- Priority: icache wins only when both slots are pending in IDLE. A request already in BUSY is never preempted.
- Ordering: a read that is served after a write's RESP exit sees the written data, for either port.
- Both resp_block_data outputs drive the shared resp_data register. Their value is meaningful only while the matching resp_valid is high.

## Timing
- While rst_aL is low:
  - FSM is in IDLE; both pending flags are 0.
  - ic_req_ready=0, dc_req_ready=1.
  - ic_resp_valid=0, dc_resp_valid=0; both resp_block_data=0.
- Reset asserted mid-request drops the request with no response. An array write happens only on the RESP exit edge, so a partial update is impossible.
- Accept at edge E0 with the engine IDLE:
  - BUSY from E1.
  - RESP from E1+MEM_LATENCY.
  - resp_valid is high in the cycle after edge E0+MEM_LATENCY+1.
- A request that waits behind the other port adds the remaining service time of the in-flight request, plus 1 cycle for IDLE arbitration.
- dc_req_ready goes high in the cycle after RESP. The earliest next dcache accept is at the following edge.
- At most one resp_valid is high in any cycle. There are no idle-cycle bubbles beyond the single IDLE arbitration cycle.

## Test plan
- Read latency (MEM_LATENCY=4): dcache WRITE of block 0x10 with data 0xDEADBEEF_CAFEF00D accepted at edge 0 → dc_resp_valid high exactly in cycle 5 with the echoed data. A dcache READ of 0x10 issued next → returns 0xDEADBEEF_CAFEF00D 5 cycles after its accept.
- Priority: ic_req_valid and dc_req_valid (READ) asserted in the same cycle → ic_resp_valid at +5, dc_resp_valid at +11. dc_req_ready stays 0 until the cycle after the dcache RESP.
- No preemption: dcache READ accepted at edge 0, icache READ accepted at edge 2 → dc_resp_valid in cycle 5, ic_resp_valid in cycle 11.
- Cross-port coherence: dcache WRITE of 0x20 = 0x1122334455667788, then icache READ of 0x20 accepted during the write's BUSY → the icache receives 0x1122334455667788.
- Aliasing: with N_BLOCKS=1024, write block 0x400 then read block 0x000 → returns the same data.
- Reset mid-BUSY: drop rst_aL 2 cycles after an accept → no resp_valid ever appears, dc_req_ready=1 after reset release, and the prior contents of the target block are unchanged.

Source files
------------

// File: rtl/main_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl_pkg / main_mem_ctrl_if
//
// Shared types and the cache <-> main-memory request/response interface.
//
// Handshake rules (both cache ports):
//   - A request is accepted on a posedge where *_req_valid and *_req_ready
//     are both high. The accepted address/type/data are captured on that edge.
//   - The master may change or drop the request fields freely once the
//     accepting edge has passed.
//   - The icache port is always ready out of reset. The icache must not
//     raise ic_req_valid again until its previous response has arrived.
//   - Each accepted request gets exactly one single-cycle *_resp_valid pulse.
//     *_resp_block_data is meaningful only while that pulse is high.
//
// Modports:
//   master : the cache side (drives requests, receives responses)
//   slave  : the memory controller side
// -----------------------------------------------------------------------------
package main_mem_ctrl_pkg;

  localparam int BLOCK_DATA_WIDTH          = 64;
  localparam int MAIN_MEM_BLOCK_ADDR_WIDTH = 26;

  typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;
  typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } eng_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } eng_owner_e;

endpackage

interface main_mem_ctrl_if;
  import main_mem_ctrl_pkg::*;

  // icache request / response
  logic                 ic_req_valid;
  main_mem_block_addr_t ic_req_block_addr;
  logic                 ic_req_ready;
  logic                 ic_resp_valid;
  block_data_t          ic_resp_block_data;

  // dcache request / response
  logic                 dc_req_valid;
  req_type_t            dc_req_type;
  main_mem_block_addr_t dc_req_block_addr;
  block_data_t          dc_req_block_data;
  logic                 dc_req_ready;
  logic                 dc_resp_valid;
  block_data_t          dc_resp_block_data;

  modport master (
    output ic_req_valid, ic_req_block_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_block_data,
    output dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
    input  dc_req_ready, dc_resp_valid, dc_resp_block_data
  );

  modport slave (
    input  ic_req_valid, ic_req_block_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_block_data,
    input  dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
    output dc_req_ready, dc_resp_valid, dc_resp_block_data
  );

endinterface

// File: rtl/main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl
//
// Main-memory controller serving the icache and dcache. Holds one request
// slot per port and a single fixed-latency engine (IDLE -> BUSY -> RESP)
// that serves one slot at a time, icache first when both are waiting.
// The block array lives here; it is not reset and survives rst_aL.
//
// Ports:
//   clk          : clock, all state changes on posedge
//   rst_aL       : asynchronous active-low reset
//   bus          : main_mem_ctrl_if.slave (both cache request/response ports)
//   dbg_state_o  : current engine state, for observation only
//
// Parameters:
//   N_BLOCKS     : number of blocks in the array (power of two)
//   MEM_LATENCY  : number of BUSY cycles per request (>= 1)
// -----------------------------------------------------------------------------
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int N_BLOCKS    = 1024,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  main_mem_ctrl_if.slave       bus,
  output eng_state_e           dbg_state_o
);

  localparam int IDX_W = $clog2(N_BLOCKS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int AW    = MAIN_MEM_BLOCK_ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  eng_state_e           state_q;
  eng_owner_e           owner_q;
  logic [CNT_W-1:0]     cnt_q;
  block_data_t          resp_data_q;
  logic                 ic_resp_valid_q;
  logic                 dc_resp_valid_q;

  logic                 ic_pending_q, ic_pending_d;
  main_mem_block_addr_t ic_addr_q,    ic_addr_d;

  logic                 dc_pending_q, dc_pending_d;
  req_type_t            dc_type_q,    dc_type_d;
  main_mem_block_addr_t dc_addr_q,    dc_addr_d;
  block_data_t          dc_data_q,    dc_data_d;

  block_data_t          mem_q [N_BLOCKS];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic ic_accept;
  logic dc_accept;
  logic ic_done;
  logic dc_done;

  // The icache is never back-pressured; it is only held off while in reset.
  assign bus.ic_req_ready = rst_aL;
  assign bus.dc_req_ready = ~dc_pending_q;

  assign ic_accept = bus.ic_req_valid & bus.ic_req_ready;
  assign dc_accept = bus.dc_req_valid & ~dc_pending_q;

  // A slot is released on the edge that leaves RESP for its owner.
  assign ic_done = (state_q == S_RESP) && (owner_q == OWN_IC);
  assign dc_done = (state_q == S_RESP) && (owner_q == OWN_DC);

  // ---------------------------------------------------------------------------
  // Request slots
  // ---------------------------------------------------------------------------
  always_comb begin
    ic_pending_d = ic_pending_q;
    ic_addr_d    = ic_addr_q;
    if (ic_done) begin
      ic_pending_d = 1'b0;
    end
    if (ic_accept) begin
      ic_pending_d = 1'b1;
      ic_addr_d    = bus.ic_req_block_addr;
    end
  end

  always_comb begin
    dc_pending_d = dc_pending_q;
    dc_type_d    = dc_type_q;
    dc_addr_d    = dc_addr_q;
    dc_data_d    = dc_data_q;
    if (dc_done) begin
      dc_pending_d = 1'b0;
    end
    if (dc_accept) begin
      dc_pending_d = 1'b1;
      dc_type_d    = bus.dc_req_type;
      dc_addr_d    = bus.dc_req_block_addr;
      dc_data_d    = bus.dc_req_block_data;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      ic_pending_q <= 1'b0;
      ic_addr_q    <= '0;
      dc_pending_q <= 1'b0;
      dc_type_q    <= READ;
      dc_addr_q    <= '0;
      dc_data_q    <= '0;
    end else begin
      ic_pending_q <= ic_pending_d;
      ic_addr_q    <= ic_addr_d;
      dc_pending_q <= dc_pending_d;
      dc_type_q    <= dc_type_d;
      dc_addr_q    <= dc_addr_d;
      dc_data_q    <= dc_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Engine view of the slot it currently owns
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] eng_idx;
  logic             eng_is_write;
  logic             mem_we;

  // Upper address bits are dropped, so block addresses alias modulo N_BLOCKS.
  assign eng_idx      = (owner_q == OWN_IC) ? ic_addr_q[IDX_W-1:0]
                                            : dc_addr_q[IDX_W-1:0];
  assign eng_is_write = (owner_q == OWN_DC) && (dc_type_q == WRITE);

  // Writes commit only on the RESP exit edge; an async reset earlier in the
  // request forces the FSM out of RESP, so a dropped write never lands.
  assign mem_we       = (state_q == S_RESP) && eng_is_write;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr_q[AW-1:IDX_W], dc_addr_q[AW-1:IDX_W]};

  // ---------------------------------------------------------------------------
  // Engine FSM (registered outputs: resp valids and resp data)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_IC;
      cnt_q           <= '0;
      resp_data_q     <= '0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Arbitration happens only here, so an in-flight request is never
          // preempted; icache wins only when both slots are waiting.
          if (ic_pending_q) begin
            state_q <= S_BUSY;
            owner_q <= OWN_IC;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
          end else if (dc_pending_q) begin
            state_q <= S_BUSY;
            owner_q <= OWN_DC;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            resp_data_q <= eng_is_write ? dc_data_q : mem_q[eng_idx];
            if (owner_q == OWN_IC) begin
              ic_resp_valid_q <= 1'b1;
            end else begin
              dc_resp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          state_q         <= S_IDLE;
          ic_resp_valid_q <= 1'b0;
          dc_resp_valid_q <= 1'b0;
        end
        default: begin
          state_q         <= S_IDLE;
          ic_resp_valid_q <= 1'b0;
          dc_resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Block array (no reset: contents persist across rst_aL)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[eng_idx] <= dc_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ic_resp_valid      = ic_resp_valid_q;
  assign bus.dc_resp_valid      = dc_resp_valid_q;
  assign bus.ic_resp_block_data = resp_data_q;
  assign bus.dc_resp_block_data = resp_data_q;
  assign dbg_state_o            = state_q;

  // ---------------------------------------------------------------------------
  // Protocol check: the icache holds at most one outstanding request.
  // ---------------------------------------------------------------------------
  ic_single_outstanding: assert property (
    @(posedge clk) disable iff (!rst_aL) !(bus.ic_req_valid && ic_pending_q)
  );

endmodule

// File: tb/tb_main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_main_mem_ctrl
//
// Directed bench for main_mem_ctrl (N_BLOCKS=1024, MEM_LATENCY=4).
// Cycle n means the cycle following the n-th posedge after the accepting
// edge; outputs are sampled on the negedge inside that cycle.
// -----------------------------------------------------------------------------
module tb_main_mem_ctrl;
  import main_mem_ctrl_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       rst_aL;
  eng_state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  main_mem_ctrl_if bus ();

  main_mem_ctrl #(
    .N_BLOCKS    (1024),
    .MEM_LATENCY (4)
  ) dut (
    .clk         (clk),
    .rst_aL      (rst_aL),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Response monitor: runs a fixed number of cycles and records what it saw.
  // ---------------------------------------------------------------------------
  int          w_ic_cyc, w_dc_cyc, w_rdy_cyc;
  int          w_ic_n, w_dc_n, w_both_n;
  block_data_t w_ic_dat, w_dc_dat;

  task automatic watch(input int ncyc);
    w_ic_cyc = -1; w_dc_cyc = -1; w_rdy_cyc = -1;
    w_ic_n = 0; w_dc_n = 0; w_both_n = 0;
    w_ic_dat = '0; w_dc_dat = '0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ic_resp_valid) begin
        w_ic_n++;
        if (w_ic_cyc < 0) begin
          w_ic_cyc = n;
          w_ic_dat = bus.ic_resp_block_data;
        end
      end
      if (bus.dc_resp_valid) begin
        w_dc_n++;
        if (w_dc_cyc < 0) begin
          w_dc_cyc = n;
          w_dc_dat = bus.dc_resp_block_data;
        end
      end
      if (bus.ic_resp_valid && bus.dc_resp_valid) w_both_n++;
      if (bus.dc_req_ready && w_rdy_cyc < 0) w_rdy_cyc = n;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers (called away from posedge; return 1 time unit after the accept)
  // ---------------------------------------------------------------------------
  task automatic dc_issue(input req_type_t t, input main_mem_block_addr_t a,
                          input block_data_t d);
    bus.dc_req_valid      = 1'b1;
    bus.dc_req_type       = t;
    bus.dc_req_block_addr = a;
    bus.dc_req_block_data = d;
    @(posedge clk);
    #1;
    bus.dc_req_valid      = 1'b0;
  endtask

  task automatic ic_issue(input main_mem_block_addr_t a);
    bus.ic_req_valid      = 1'b1;
    bus.ic_req_block_addr = a;
    @(posedge clk);
    #1;
    bus.ic_req_valid      = 1'b0;
  endtask

  task automatic both_issue(input main_mem_block_addr_t ia, input main_mem_block_addr_t da);
    bus.ic_req_valid      = 1'b1;
    bus.ic_req_block_addr = ia;
    bus.dc_req_valid      = 1'b1;
    bus.dc_req_type       = READ;
    bus.dc_req_block_addr = da;
    @(posedge clk);
    #1;
    bus.ic_req_valid      = 1'b0;
    bus.dc_req_valid      = 1'b0;
  endtask

  // Icache request accepted on the second posedge after the caller's accept.
  task automatic ic_issue_at_edge2(input main_mem_block_addr_t a);
    @(posedge clk);
    @(negedge clk);
    ic_issue(a);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam block_data_t D_BEEF  = 64'hDEADBEEF_CAFEF00D;
  localparam block_data_t D_1122  = 64'h11223344_55667788;
  localparam block_data_t D_ALIAS = 64'hA5A5_0000_5A5A_FFFF;
  localparam block_data_t D_KEEP  = 64'h0123_4567_89AB_CDEF;
  localparam block_data_t D_LOST  = 64'hFFFF_EEEE_DDDD_CCCC;

  initial begin
    rst_aL                = 1'b0;
    bus.ic_req_valid      = 1'b0;
    bus.ic_req_block_addr = '0;
    bus.dc_req_valid      = 1'b0;
    bus.dc_req_type       = READ;
    bus.dc_req_block_addr = '0;
    bus.dc_req_block_data = '0;

    // --- reset values --------------------------------------------------------
    repeat (2) @(negedge clk);
    check("rst_ic_ready",   64'(bus.ic_req_ready),       64'd0);
    check("rst_dc_ready",   64'(bus.dc_req_ready),       64'd1);
    check("rst_ic_rvalid",  64'(bus.ic_resp_valid),      64'd0);
    check("rst_dc_rvalid",  64'(bus.dc_resp_valid),      64'd0);
    check("rst_ic_rdata",   bus.ic_resp_block_data,      64'd0);
    check("rst_dc_rdata",   bus.dc_resp_block_data,      64'd0);
    check("rst_state",      64'(dbg_state),              64'(S_IDLE));
    rst_aL = 1'b1;
    @(negedge clk);
    check("ic_ready_after_rst", 64'(bus.ic_req_ready),   64'd1);

    // --- dcache write then read of 0x10 --------------------------------------
    dc_issue(WRITE, 26'h10, D_BEEF);
    watch(8);
    check("wr_dc_cyc",   64'(w_dc_cyc),  64'd5);
    check("wr_dc_data",  w_dc_dat,       D_BEEF);
    check("wr_dc_count", 64'(w_dc_n),    64'd1);
    check("wr_ic_count", 64'(w_ic_n),    64'd0);
    check("wr_rdy_cyc",  64'(w_rdy_cyc), 64'd6);

    dc_issue(READ, 26'h10, '0);
    exp_q.push_back(D_BEEF);
    watch(8);
    check("rd_dc_cyc",   64'(w_dc_cyc),  64'd5);
    check("rd_dc_data",  w_dc_dat,       exp_q.pop_front());
    check("rd_dc_count", 64'(w_dc_n),    64'd1);

    // --- priority: both ports in the same cycle ------------------------------
    both_issue(26'h10, 26'h10);
    watch(14);
    check("pri_ic_cyc",  64'(w_ic_cyc),  64'd5);
    check("pri_ic_data", w_ic_dat,       D_BEEF);
    check("pri_dc_cyc",  64'(w_dc_cyc),  64'd11);
    check("pri_dc_data", w_dc_dat,       D_BEEF);
    check("pri_rdy_cyc", 64'(w_rdy_cyc), 64'd12);
    check("pri_overlap", 64'(w_both_n),  64'd0);
    check("pri_ic_n",    64'(w_ic_n),    64'd1);
    check("pri_dc_n",    64'(w_dc_n),    64'd1);

    // --- no preemption: dcache at edge 0, icache at edge 2 -------------------
    dc_issue(READ, 26'h10, '0);
    fork
      watch(14);
      ic_issue_at_edge2(26'h10);
    join
    check("npe_dc_cyc",  64'(w_dc_cyc),  64'd5);
    check("npe_ic_cyc",  64'(w_ic_cyc),  64'd11);
    check("npe_ic_data", w_ic_dat,       D_BEEF);
    check("npe_overlap", 64'(w_both_n),  64'd0);

    // --- cross-port coherence: icache reads what the dcache is writing -------
    dc_issue(WRITE, 26'h20, D_1122);
    fork
      watch(14);
      ic_issue_at_edge2(26'h20);
    join
    check("coh_dc_cyc",  64'(w_dc_cyc),  64'd5);
    check("coh_dc_data", w_dc_dat,       D_1122);
    check("coh_ic_cyc",  64'(w_ic_cyc),  64'd11);
    check("coh_ic_data", w_ic_dat,       D_1122);

    // --- aliasing: 0x400 and 0x000 share an entry ----------------------------
    dc_issue(WRITE, 26'h400, D_ALIAS);
    watch(8);
    check("alias_wr_cyc", 64'(w_dc_cyc), 64'd5);
    dc_issue(READ, 26'h000, '0);
    watch(8);
    check("alias_rd_data", w_dc_dat,     D_ALIAS);
    check("alias_rd_cyc", 64'(w_dc_cyc), 64'd5);

    // --- reset in the middle of BUSY drops the write -------------------------
    dc_issue(WRITE, 26'h30, D_KEEP);
    watch(8);
    check("keep_wr_cyc", 64'(w_dc_cyc),  64'd5);

    dc_issue(WRITE, 26'h30, D_LOST);
    fork
      watch(12);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_aL = 1'b0;
        repeat (3) @(negedge clk);
        rst_aL = 1'b1;
      end
    join
    check("rstmid_dc_n",  64'(w_dc_n),           64'd0);
    check("rstmid_ic_n",  64'(w_ic_n),           64'd0);
    check("rstmid_ready", 64'(bus.dc_req_ready), 64'd1);
    check("rstmid_state", 64'(dbg_state),        64'(S_IDLE));

    dc_issue(READ, 26'h30, '0);
    watch(8);
    check("rstmid_keep_cyc",  64'(w_dc_cyc), 64'd5);
    check("rstmid_keep_data", w_dc_dat,      D_KEEP);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
